ibex_multdiv_issue: RTL and testbench

//  Initiator for the slow mult/div engine. Takes decoded MUL/DIV ops on a valid/ready request channel.

---
 rtl/ibex_pkg.sv | 22 ++
 rtl/ibex_multdiv_issue_cache.sv | 49 ++++
 rtl/ibex_multdiv_issue.sv | 163 ++++++++++++++++
 tb/tb_ibex_multdiv_issue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared mult/div types: engine operator encoding and issue-FSM states.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ISSUE_IDLE,
    MD_ISSUE_BUSY,
    MD_ISSUE_DRAIN,
    MD_ISSUE_RESP
  } md_issue_e;

  function automatic logic md_is_mult(md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_multdiv_issue_cache.sv
// Single-entry mult/div result cache: exact match on {op, signed, a, b}.
module ibex_multdiv_issue_cache import ibex_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        fill_i,
  input  md_op_e      fill_op_i,
  input  logic [1:0]  fill_signed_i,
  input  logic [31:0] fill_a_i,
  input  logic [31:0] fill_b_i,
  input  logic [31:0] fill_result_i,
  input  md_op_e      lookup_op_i,
  input  logic [1:0]  lookup_signed_i,
  input  logic [31:0] lookup_a_i,
  input  logic [31:0] lookup_b_i,
  output logic        hit_o,
  output logic [31:0] hit_result_o
);

  logic        vld_q;
  md_op_e      op_q;
  logic [1:0]  signed_q;
  logic [31:0] a_q, b_q, result_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q    <= 1'b0;
      op_q     <= MD_OP_MULL;
      signed_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else if (clear_i) begin
      vld_q <= 1'b0;
    end else if (fill_i) begin
      vld_q    <= 1'b1;
      op_q     <= fill_op_i;
      signed_q <= fill_signed_i;
      a_q      <= fill_a_i;
      b_q      <= fill_b_i;
      result_q <= fill_result_i;
    end
  end

  assign hit_o = vld_q && (op_q == lookup_op_i) && (signed_q == lookup_signed_i) &&
                 (a_q == lookup_a_i) && (b_q == lookup_b_i);
  assign hit_result_o = result_q;

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Request/response front end for the multi-cycle mult/div engine, one op in flight.
// Optional single-entry result cache enabled by defining MULTDIV_ISSUE_RESULT_CACHE_EN.
module ibex_multdiv_issue import ibex_pkg::*; #(
  parameter int unsigned TagW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  md_op_e          req_op_i,
  input  logic [1:0]      req_signed_i,
  input  logic [31:0]     req_a_i,
  input  logic [31:0]     req_b_i,
  input  logic [TagW-1:0] req_tag_i,
  input  logic            data_ind_timing_i,
  input  logic            flush_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_result_o,
  output logic [TagW-1:0] rsp_tag_o,
  output logic            md_mult_en_o,
  output logic            md_div_en_o,
  output logic            md_mult_sel_o,
  output logic            md_div_sel_o,
  output md_op_e          md_operator_o,
  output logic [1:0]      md_signed_o,
  output logic [31:0]     md_a_o,
  output logic [31:0]     md_b_o,
  output logic            md_ready_id_o,
  input  logic            md_valid_i,
  input  logic [31:0]     md_result_i
);

  md_issue_e       state_q;
  md_op_e          op_q;
  logic [1:0]      signed_q;
  logic [31:0]     a_q, b_q, result_q;
  logic [TagW-1:0] tag_q;
  logic            mult_q, div_q, ready_id_q, rsp_valid_q;
  logic            accept, cache_hit;
  logic [31:0]     cached_result;

  assign req_ready_o = ~rst_i & ~flush_i &
                       ((state_q == MD_ISSUE_IDLE) | ((state_q == MD_ISSUE_RESP) & rsp_ready_i));
  assign accept = req_valid_i & req_ready_o;

`ifdef MULTDIV_ISSUE_RESULT_CACHE_EN
  logic cache_match, cache_fill;

  // Results that were dropped by a flush never enter the cache.
  assign cache_fill = (state_q == MD_ISSUE_BUSY) & md_valid_i & ~flush_i;

  ibex_multdiv_issue_cache u_cache (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (flush_i),
    .fill_i          (cache_fill),
    .fill_op_i       (op_q),
    .fill_signed_i   (signed_q),
    .fill_a_i        (a_q),
    .fill_b_i        (b_q),
    .fill_result_i   (md_result_i),
    .lookup_op_i     (req_op_i),
    .lookup_signed_i (req_signed_i),
    .lookup_a_i      (req_a_i),
    .lookup_b_i      (req_b_i),
    .hit_o           (cache_match),
    .hit_result_o    (cached_result)
  );

  assign cache_hit = cache_match & ~data_ind_timing_i;
`else
  logic unused_data_ind_timing;
  assign unused_data_ind_timing = data_ind_timing_i;
  assign cache_hit     = 1'b0;
  assign cached_result = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= MD_ISSUE_IDLE;
      op_q        <= MD_OP_MULL;
      signed_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      result_q    <= '0;
      mult_q      <= 1'b0;
      div_q       <= 1'b0;
      ready_id_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        MD_ISSUE_BUSY: begin
          if (md_valid_i) begin
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            ready_id_q <= 1'b0;
            if (flush_i) begin
              state_q <= MD_ISSUE_IDLE;
            end else begin
              result_q    <= md_result_i;
              rsp_valid_q <= 1'b1;
              state_q     <= MD_ISSUE_RESP;
            end
          end else if (flush_i) begin
            state_q <= MD_ISSUE_DRAIN;
          end
        end
        // The engine cannot be aborted, so keep it enabled until it finishes.
        MD_ISSUE_DRAIN: begin
          if (md_valid_i) begin
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            ready_id_q <= 1'b0;
            state_q    <= MD_ISSUE_IDLE;
          end
        end
        MD_ISSUE_RESP: begin
          if (flush_i | rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= MD_ISSUE_IDLE;
          end
        end
        default: ;
      endcase

      // Accept only happens in IDLE or a completing RESP, so it overrides the above.
      if (accept) begin
        op_q     <= req_op_i;
        signed_q <= req_signed_i;
        a_q      <= req_a_i;
        b_q      <= req_b_i;
        tag_q    <= req_tag_i;
        if (cache_hit) begin
          result_q    <= cached_result;
          rsp_valid_q <= 1'b1;
          state_q     <= MD_ISSUE_RESP;
        end else begin
          mult_q      <= md_is_mult(req_op_i);
          div_q       <= ~md_is_mult(req_op_i);
          ready_id_q  <= 1'b1;
          rsp_valid_q <= 1'b0;
          state_q     <= MD_ISSUE_BUSY;
        end
      end
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_result_o  = result_q;
  assign rsp_tag_o     = tag_q;
  assign md_mult_en_o  = mult_q;
  assign md_mult_sel_o = mult_q;
  assign md_div_en_o   = div_q;
  assign md_div_sel_o  = div_q;
  assign md_operator_o = op_q;
  assign md_signed_o   = signed_q;
  assign md_a_o        = a_q;
  assign md_b_o        = b_q;
  assign md_ready_id_o = ready_id_q;

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Scoreboard bench for ibex_multdiv_issue with a behavioural multi-cycle engine model.
module tb_ibex_multdiv_issue;
  import ibex_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  md_op_e      req_op_i = MD_OP_MULL;
  logic [1:0]  req_signed_i = '0;
  logic [31:0] req_a_i = '0, req_b_i = '0;
  logic [4:0]  req_tag_i = '0;
  logic        data_ind_timing_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_tag_o;
  logic        md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
  md_op_e      md_operator_o;
  logic [1:0]  md_signed_o;
  logic [31:0] md_a_o, md_b_o;
  logic        md_ready_id_o;
  logic        md_valid_i = 1'b0;
  logic [31:0] md_result_i = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int          eng_state = 0;
  int          eng_cnt = 0;
  int          eng_lat = 3;
  int          en_cnt = 0;
  bit          flushing = 1'b0;
  logic [31:0] snap_a, snap_b;

  ibex_multdiv_issue #(.TagW(5)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_op_i          (req_op_i),
    .req_signed_i      (req_signed_i),
    .req_a_i           (req_a_i),
    .req_b_i           (req_b_i),
    .req_tag_i         (req_tag_i),
    .data_ind_timing_i (data_ind_timing_i),
    .flush_i           (flush_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_result_o      (rsp_result_o),
    .rsp_tag_o         (rsp_tag_o),
    .md_mult_en_o      (md_mult_en_o),
    .md_div_en_o       (md_div_en_o),
    .md_mult_sel_o     (md_mult_sel_o),
    .md_div_sel_o      (md_div_sel_o),
    .md_operator_o     (md_operator_o),
    .md_signed_o       (md_signed_o),
    .md_a_o            (md_a_o),
    .md_b_o            (md_b_o),
    .md_ready_id_o     (md_ready_id_o),
    .md_valid_i        (md_valid_i),
    .md_result_i       (md_result_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] calc(md_op_e op, logic [1:0] s, logic [31:0] a, logic [31:0] b);
    logic signed [32:0] xa, xb;
    logic signed [65:0] p;
    xa = {s[0] & a[31], a};
    xb = {s[1] & b[31], b};
    p  = xa * xb;
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'(xa / xb);
      default:    return (b == 0) ? a : 32'(xa % xb);
    endcase
  endfunction

  // Engine model: starts on enable, answers after eng_lat cycles with a one-cycle valid.
  always @(negedge clk) begin
    if (md_mult_en_o || md_div_en_o) en_cnt++;
    if (rst_i) begin
      eng_state  = 0;
      md_valid_i = 1'b0;
    end else begin
      case (eng_state)
        0: if (md_mult_en_o || md_div_en_o) begin
          eng_state = 1;
          eng_cnt   = eng_lat;
          snap_a    = md_a_o;
          snap_b    = md_b_o;
        end
        1: begin
          chk("en_held", {31'b0, (md_mult_en_o | md_div_en_o) & md_ready_id_o}, 32'd1);
          if (eng_cnt == 0) begin
            chk("op_a_stable", md_a_o, snap_a);
            chk("op_b_stable", md_b_o, snap_b);
            md_result_i = calc(md_operator_o, md_signed_o, md_a_o, md_b_o);
            md_valid_i  = 1'b1;
            eng_state   = 2;
          end else begin
            eng_cnt--;
          end
        end
        default: begin
          md_valid_i = 1'b0;
          if (!flushing) chk("rsp_latency", {31'b0, rsp_valid_o}, 32'd1);
          eng_state = 0;
        end
      endcase
    end
  end

  // Monitor: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual result=%h tag=%0d required none", rsp_result_o, rsp_tag_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", rsp_result_o, e.res);
        chk("rsp_tag", {27'b0, rsp_tag_o}, {27'b0, e.tag});
      end
    end
  end

  task automatic issue(input md_op_e op, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                       input bit push, input bit dit, output int waited);
    exp_t e;
    req_op_i = op; req_signed_i = s; req_a_i = a; req_b_i = b; req_tag_i = tag;
    data_ind_timing_i = dit;
    req_valid_i = 1'b1;
    for (waited = 0; waited < 100; waited++) begin
      @(negedge clk);
      if (req_ready_o) break;
    end
    if (waited >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not accepted required=accepted tag=%0d", tag);
    end else if (push) begin
      e.res = exp;
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    data_ind_timing_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, e0, n;

    #2;
    chk("rst_req_ready", {31'b0, req_ready_o}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_mult_en", {31'b0, md_mult_en_o}, 32'd0);
    chk("rst_md_a", md_a_o, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Basic ops, issued back to back.
    issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 1, 0, w);
    issue(MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 1, 0, w);
    issue(MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 1, 0, w);
    issue(MD_OP_DIV,  2'b00, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1, 0, w);
    issue(MD_OP_REM,  2'b00, 32'd7, 32'd0, 5'd9, 32'd7, 1, 0, w);
    wait_idle();

    // Response back-pressure.
    rsp_ready_i = 1'b0;
    issue(MD_OP_MULL, 2'b00, 32'd3, 32'd5, 5'd7, 32'd15, 1, 0, w);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rsp_valid_o) break;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout actual=0 required=1");
    end
    req_op_i = MD_OP_REM; req_signed_i = 2'b00; req_a_i = 32'd100; req_b_i = 32'd7;
    req_tag_i = 5'd8; req_valid_i = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_result", rsp_result_o, 32'd15);
      chk("stall_tag", {27'b0, rsp_tag_o}, 32'd7);
      chk("stall_req_ready", {31'b0, req_ready_o}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready_i = 1'b1;
    issue(MD_OP_REM, 2'b00, 32'd100, 32'd7, 5'd8, 32'd2, 1, 0, w);
    chk("release_accept_wait", w, 32'd0);
    wait_idle();

    // Flush during a DIV: engine kept enabled, result dropped.
    flushing = 1'b1;
    eng_lat  = 8;
    issue(MD_OP_DIV, 2'b00, 32'd100, 32'd3, 5'd14, 32'd0, 0, 0, w);
    repeat (2) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (md_valid_i) break;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_md_valid actual=0 required=1");
    end
    repeat (3) @(negedge clk);
    chk("flush_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("flush_div_en", {31'b0, md_div_en_o}, 32'd0);
    chk("flush_idle_ready", {31'b0, req_ready_o}, 32'd1);
    flushing = 1'b0;
    eng_lat  = 3;
    @(posedge clk); #1;
    issue(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 1, 0, w);
    wait_idle();

    // Reset in the middle of an op.
    issue(MD_OP_DIV, 2'b00, 32'd9, 32'd2, 5'd15, 32'd0, 0, 0, w);
    @(posedge clk); #1 rst_i = 1'b1;
    #1;
    chk("midrst_req_ready", {31'b0, req_ready_o}, 32'd0);
    chk("midrst_div_en", {31'b0, md_div_en_o}, 32'd0);
    chk("midrst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1;

    // Repeated op: served from the cache when built with it, else through the engine.
    issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd11, 32'd42, 1, 0, w);
    wait_idle();
    e0 = en_cnt;
    issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd12, 32'd42, 1, 0, w);
`ifdef MULTDIV_ISSUE_RESULT_CACHE_EN
    chk("cache_hit_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    wait_idle();
    chk("cache_hit_no_engine", en_cnt, e0);
`else
    wait_idle();
    chk("no_cache_engine_used", {31'b0, en_cnt > e0}, 32'd1);
`endif
    e0 = en_cnt;
    issue(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd13, 32'd42, 1, 1, w);
    chk("dit_rsp_not_immediate", {31'b0, rsp_valid_o}, 32'd0);
    wait_idle();
    chk("dit_engine_used", {31'b0, en_cnt > e0}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
